// File: rtl/alarm_sequencer.sv
// ============================================================================
// alarm_sequencer
// ----------------------------------------------------------------------------
// Purpose:
//   Plays the egg-timer alarm. When the countdown reports that it has expired,
//   this block alternates tone-on (BEEP) and silent (GAP) phases. Each new beep
//   moves to the next tone in the tone generator's table. The alarm stops when
//   the user presses the stop button, or on its own after a fixed number of
//   beats. It also reports its status to the display/control FSM.
//
// Ports:
//   pulse_17MHz    in   1  system clock, all logic on the rising edge
//   reset          in   1  asynchronous reset, active low (0 = reset)
//   endtime        in   1  one-cycle pulse from the countdown: timer hit zero
//   ack            in   1  debounced stop button, level, active high
//   audioselection out  4  tone select for the tone generator (registered)
//   audio_en       out  1  1 = tone audible, ANDed with the PWM downstream
//   alarm_active   out  1  1 while the alarm is sounding (BEEP or GAP)
//   done           out  1  one-cycle pulse when the alarm times out by itself
//
// Parameters:
//   TICK_DIV     clock cycles per beat (>= 2)
//   BEEP_BEATS   beats per tone-on phase (>= 1)
//   GAP_BEATS    beats per silent phase (>= 1)
//   ALARM_BEATS  total beats before the alarm stops by itself (>= BEEP_BEATS)
//   NUM_TONES    number of tones cycled through, 0..NUM_TONES-1 (<= 16)
// ============================================================================
module alarm_sequencer #(
    parameter int TICK_DIV    = 1700000,
    parameter int BEEP_BEATS  = 3,
    parameter int GAP_BEATS   = 2,
    parameter int ALARM_BEATS = 300,
    parameter int NUM_TONES   = 5
) (
    input  logic       pulse_17MHz,
    input  logic       reset,
    input  logic       endtime,
    input  logic       ack,
    output logic [3:0] audioselection,
    output logic       audio_en,
    output logic       alarm_active,
    output logic       done
);

    // ------------------------------------------------------------------------
    // Counter widths and terminal values
    // ------------------------------------------------------------------------
    localparam int TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PHASE_MAX = (BEEP_BEATS > GAP_BEATS) ? BEEP_BEATS : GAP_BEATS;
    localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
    localparam int TOTAL_W   = $clog2(ALARM_BEATS + 1);

    localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [PHASE_W-1:0] BEEP_LEN  = PHASE_W'(BEEP_BEATS);
    localparam logic [PHASE_W-1:0] GAP_LEN   = PHASE_W'(GAP_BEATS);
    localparam logic [TOTAL_W-1:0] TOTAL_LEN = TOTAL_W'(ALARM_BEATS);
    localparam logic [3:0]         TONE_LAST = 4'(NUM_TONES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BEEP     = 2'd1,
        GAP      = 2'd2,
        ACK_WAIT = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [TICK_W-1:0]   tick_cnt;
    logic [TICK_W-1:0]   tick_next;
    logic [PHASE_W-1:0]  phase_cnt;
    logic [PHASE_W-1:0]  phase_next;
    logic [PHASE_W-1:0]  phase_inc;
    logic [TOTAL_W-1:0]  total_cnt;
    logic [TOTAL_W-1:0]  total_next;
    logic [TOTAL_W-1:0]  total_inc;
    logic [3:0]          tone_idx;
    logic [3:0]          tone_next;

    logic                beat;
    logic                done_next;
    logic                audio_en_next;
    logic                alarm_active_next;

    // ------------------------------------------------------------------------
    // A beat is the last cycle of each TICK_DIV-cycle window. The tick counter
    // only runs while the alarm is sounding, so a beat can only happen in BEEP
    // or GAP. The incremented phase and total counts are computed once here and
    // shared by the next-state logic below.
    // ------------------------------------------------------------------------
    always_comb begin
        beat      = (tick_cnt == TICK_LAST);
        phase_inc = phase_cnt + PHASE_W'(1);
        total_inc = total_cnt + TOTAL_W'(1);
    end

    // ------------------------------------------------------------------------
    // Next-state and counter logic. The checks are nested in priority order:
    // ack beats timeout, and timeout beats a BEEP/GAP phase change. An endtime
    // pulse only counts in IDLE. In every other state it is ignored, which is
    // why a held stop button in ACK_WAIT cannot retrigger the alarm.
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        tick_next  = tick_cnt;
        phase_next = phase_cnt;
        total_next = total_cnt;
        tone_next  = tone_idx;
        done_next  = 1'b0;

        case (state)
            IDLE: begin
                if (endtime && !ack) begin
                    state_next = BEEP;
                    tick_next  = '0;
                    phase_next = '0;
                    total_next = '0;
                    tone_next  = 4'd0;
                end
            end

            BEEP, GAP: begin
                if (ack) begin
                    state_next = ACK_WAIT;
                end else begin
                    tick_next = beat ? '0 : tick_cnt + TICK_W'(1);
                    if (beat) begin
                        phase_next = phase_inc;
                        total_next = total_inc;
                        if (total_inc == TOTAL_LEN) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end else if (state == BEEP && phase_inc == BEEP_LEN) begin
                            state_next = GAP;
                            phase_next = '0;
                        end else if (state == GAP && phase_inc == GAP_LEN) begin
                            state_next = BEEP;
                            phase_next = '0;
                            tone_next  = (tone_idx == TONE_LAST) ? 4'd0
                                                                 : tone_idx + 4'd1;
                        end
                    end
                end
            end

            ACK_WAIT: begin
                if (!ack) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // The outputs are decoded from the next state, then registered. This way
    // they change in the same cycle the state register does, with no extra
    // cycle of latency. audioselection follows tone_next, so it takes the new
    // tone in the same cycle audio_en comes back on. On a timeout it keeps
    // its last value.
    // ------------------------------------------------------------------------
    always_comb begin
        audio_en_next     = (state_next == BEEP);
        alarm_active_next = (state_next == BEEP) || (state_next == GAP);
    end

    // ------------------------------------------------------------------------
    // State and counter registers.
    // ------------------------------------------------------------------------
    always_ff @(posedge pulse_17MHz or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            phase_cnt <= '0;
            total_cnt <= '0;
            tone_idx  <= 4'd0;
        end else begin
            state     <= state_next;
            tick_cnt  <= tick_next;
            phase_cnt <= phase_next;
            total_cnt <= total_next;
            tone_idx  <= tone_next;
        end
    end

    // ------------------------------------------------------------------------
    // Registered outputs. Reset clears them immediately, so a reset in the
    // middle of an alarm never produces a done pulse.
    // ------------------------------------------------------------------------
    always_ff @(posedge pulse_17MHz or negedge reset) begin
        if (!reset) begin
            audioselection <= 4'd0;
            audio_en       <= 1'b0;
            alarm_active   <= 1'b0;
            done           <= 1'b0;
        end else begin
            audioselection <= tone_next;
            audio_en       <= audio_en_next;
            alarm_active   <= alarm_active_next;
            done           <= done_next;
        end
    end

endmodule

// File: tb/tb_alarm_sequencer.sv
// ============================================================================
// tb_alarm_sequencer
// ----------------------------------------------------------------------------
// Directed testbench for alarm_sequencer. It uses a small configuration:
// TICK_DIV=4, BEEP_BEATS=2, GAP_BEATS=1, ALARM_BEATS=10, NUM_TONES=5.
// With these values a beep lasts 8 cycles, a gap lasts 4 cycles, and the
// alarm times out 40 cycles after it starts.
// Inputs are driven and outputs are sampled on the falling clock edge.
// ============================================================================
module tb_alarm_sequencer;

    logic       clock;
    logic       resetN;
    logic       endtime;
    logic       ack;
    logic [3:0] audioSelection;
    logic       audioEn;
    logic       alarmActive;
    logic       done;

    int assertCount;
    int failCount;
    int doneCount;
    int doneBase;

    alarm_sequencer #(
        .TICK_DIV    (4),
        .BEEP_BEATS  (2),
        .GAP_BEATS   (1),
        .ALARM_BEATS (10),
        .NUM_TONES   (5)
    ) dut (
        .pulse_17MHz    (clock),
        .reset          (resetN),
        .endtime        (endtime),
        .ack            (ack),
        .audioselection (audioSelection),
        .audio_en       (audioEn),
        .alarm_active   (alarmActive),
        .done           (done)
    );

    // Free-running clock, period 10
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Counts every cycle in which done is high, sampled on the falling edge
    initial doneCount = 0;
    always @(negedge clock) begin
        if (done === 1'b1) doneCount <= doneCount + 1;
    end

    // Drives the two control inputs
    task automatic applyStimulus(input logic endtimeVal, input logic ackVal);
        endtime = endtimeVal;
        ack     = ackVal;
    endtask

    // Counts one comparison and reports it if the values differ
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        resetN      = 1'b0;
        applyStimulus(1'b0, 1'b0);

        // Reset state
        repeat (3) @(negedge clock);
        checkOutput("rst_audioEn",  32'(audioEn),        32'd0);
        checkOutput("rst_active",   32'(alarmActive),    32'd0);
        checkOutput("rst_done",     32'(done),           32'd0);
        checkOutput("rst_toneSel",  32'(audioSelection), 32'd0);
        resetN = 1'b1;

        // Stay idle for 50 cycles
        repeat (50) @(negedge clock);
        checkOutput("idle_audioEn", 32'(audioEn),        32'd0);
        checkOutput("idle_active",  32'(alarmActive),    32'd0);
        checkOutput("idle_done",    32'(done),           32'd0);
        checkOutput("idle_toneSel", 32'(audioSelection), 32'd0);

        // ack and endtime in the same IDLE cycle: ack wins
        applyStimulus(1'b1, 1'b1);
        @(negedge clock);
        applyStimulus(1'b0, 1'b0);
        checkOutput("both_audioEn", 32'(audioEn),     32'd0);
        checkOutput("both_active",  32'(alarmActive), 32'd0);
        @(negedge clock);
        checkOutput("both_audioEn2", 32'(audioEn),    32'd0);

        // Free run from endtime up to the timeout
        applyStimulus(1'b1, 1'b0);
        @(negedge clock);
        applyStimulus(1'b0, 1'b0);
        doneBase = doneCount;
        for (int k = 0; k < 40; k++) begin
            checkOutput("run_audioEn", 32'(audioEn), ((k % 12) < 8) ? 32'd1 : 32'd0);
            checkOutput("run_toneSel", 32'(audioSelection), 32'(k / 12));
            checkOutput("run_active",  32'(alarmActive), 32'd1);
            checkOutput("run_done",    32'(done), 32'd0);
            @(negedge clock);
        end
        checkOutput("to_audioEn",  32'(audioEn),        32'd0);
        checkOutput("to_active",   32'(alarmActive),    32'd0);
        checkOutput("to_done",     32'(done),           32'd1);
        checkOutput("to_toneSel",  32'(audioSelection), 32'd3);
        @(negedge clock);
        checkOutput("to_doneDrop", 32'(done),           32'd0);
        checkOutput("to_toneHold", 32'(audioSelection), 32'd3);
        repeat (3) @(negedge clock);
        checkOutput("to_donePulses", 32'(doneCount - doneBase), 32'd1);

        // Restart, then press ack mid-BEEP and pulse endtime while it is held
        applyStimulus(1'b1, 1'b0);
        @(negedge clock);
        applyStimulus(1'b0, 1'b0);
        checkOutput("ack_startEn",  32'(audioEn),        32'd1);
        checkOutput("ack_startSel", 32'(audioSelection), 32'd0);
        repeat (3) @(negedge clock);
        checkOutput("ack_midBeep", 32'(audioEn), 32'd1);
        doneBase = doneCount;
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            checkOutput("ack_audioEn", 32'(audioEn),     32'd0);
            checkOutput("ack_active",  32'(alarmActive), 32'd0);
            checkOutput("ack_done",    32'(done),        32'd0);
            applyStimulus((i == 10) ? 1'b1 : 1'b0, 1'b1);
        end
        // Release ack in the same cycle as an endtime pulse: ACK_WAIT ignores it
        applyStimulus(1'b1, 1'b0);
        @(negedge clock);
        applyStimulus(1'b0, 1'b0);
        checkOutput("rel_audioEn", 32'(audioEn),     32'd0);
        checkOutput("rel_active",  32'(alarmActive), 32'd0);
        @(negedge clock);
        checkOutput("rel_audioEn2", 32'(audioEn), 32'd0);
        // Back in IDLE: a fresh endtime starts the alarm again
        applyStimulus(1'b1, 1'b0);
        @(negedge clock);
        applyStimulus(1'b0, 1'b0);
        checkOutput("re_audioEn", 32'(audioEn),        32'd1);
        checkOutput("re_active",  32'(alarmActive),    32'd1);
        checkOutput("re_toneSel", 32'(audioSelection), 32'd0);
        checkOutput("ack_noDone", 32'(doneCount - doneBase), 32'd0);

        // Move into the second GAP (tone 1 was last), then reset asynchronously
        repeat (20) @(negedge clock);
        checkOutput("gap_audioEn", 32'(audioEn),        32'd0);
        checkOutput("gap_active",  32'(alarmActive),    32'd1);
        checkOutput("gap_toneSel", 32'(audioSelection), 32'd1);
        #2 resetN = 1'b0;
        #1;
        checkOutput("arst_audioEn", 32'(audioEn),        32'd0);
        checkOutput("arst_active",  32'(alarmActive),    32'd0);
        checkOutput("arst_toneSel", 32'(audioSelection), 32'd0);
        checkOutput("arst_done",    32'(done),           32'd0);
        @(negedge clock);
        resetN = 1'b1;
        repeat (5) @(negedge clock);
        checkOutput("post_audioEn", 32'(audioEn), 32'd0);
        applyStimulus(1'b1, 1'b0);
        @(negedge clock);
        applyStimulus(1'b0, 1'b0);
        checkOutput("post_startEn",  32'(audioEn),        32'd1);
        checkOutput("post_active",   32'(alarmActive),    32'd1);
        checkOutput("post_toneSel",  32'(audioSelection), 32'd0);
        checkOutput("post_noDone",   32'(doneCount - doneBase), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/alarm_sequencer.md
Name: alarm_sequencer

Overview:
- Sits directly upstream of the tone generator in the egg-timer audio path.
- On the countdown-expired pulse, runs a timed beep/gap alarm pattern:
  - drives the tone generator's 4-bit `audioselection` input;
  - gates its PWM output via `audio_en`.
- Stops on user acknowledge or after a fixed timeout.
- Reports status to the display/control FSM.

Parameters:
- TICK_DIV, 1700000, clock cycles per beat (100 ms at 17 MHz); must be >= 2.
- BEEP_BEATS, 3, beats per tone-on phase; >= 1.
- GAP_BEATS, 2, beats per silent phase; >= 1.
- ALARM_BEATS, 300, total beats before auto-stop (30 s); >= BEEP_BEATS.
- NUM_TONES, 5, number of tone selections cycled, values 0..NUM_TONES-1; <= 16.

Ports:
- pulse_17MHz  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset.
- endtime  in  1  one-cycle pulse from the countdown: timer reached zero.
- ack  in  1  debounced user stop button, level, active-high.
- audioselection  out  4  tone select to the tone generator; registered.
- audio_en  out  1  1 = tone audible; downstream ANDs it with its PWM; registered.
- alarm_active  out  1  1 while in BEEP or GAP; registered.
- done  out  1  one-cycle pulse on timeout completion only; registered.

Behaviour:
- Reset (reset=0, async): state=IDLE, all counters 0, audioselection=0, audio_en=0, alarm_active=0, done=0.
- States:
  - IDLE: waiting for `endtime`.
  - BEEP: tone on.
  - GAP: tone off.
  - ACK_WAIT: wait for `ack` release.
- Counters:
  - tick_cnt: 0..TICK_DIV-1. A "beat" event occurs in the cycle where tick_cnt == TICK_DIV-1; tick_cnt then wraps to 0.
  - phase_cnt: beats elapsed in the current phase.
  - total_cnt: beats since alarm start, width clog2(ALARM_BEATS+1).
  - tone_idx: 0..NUM_TONES-1.
  - All counters hold in IDLE and ACK_WAIT.
- IDLE:
  - endtime=1 and ack=0 -> BEEP. Next cycle: audio_en=1, alarm_active=1, audioselection=0. tick_cnt, phase_cnt, total_cnt and tone_idx all cleared to 0.
  - endtime=1 and ack=1 in the same cycle: ack wins, stay IDLE.
  - Latency from endtime edge to audio_en=1: 1 cycle.
- BEEP:
  - On a beat, phase_cnt increments and total_cnt increments.
  - When phase_cnt reaches BEEP_BEATS -> GAP. Next cycle audio_en=0, phase_cnt=0.
  - BEEP lasts exactly BEEP_BEATS*TICK_DIV cycles.
- GAP:
  - audio_en=0, alarm_active=1.
  - After GAP_BEATS beats -> BEEP. On that transition, tone_idx = (tone_idx+1) mod NUM_TONES and audioselection takes the new tone_idx in the same cycle audio_en returns to 1.
- Timeout:
  - On the beat where total_cnt becomes ALARM_BEATS -> IDLE, in BEEP or GAP.
  - Next cycle: audio_en=0, alarm_active=0, done=1 for exactly one cycle.
  - audioselection holds its last value.
  - Timeout takes precedence over a BEEP/GAP phase change on the same beat.
- ack=1 in BEEP or GAP -> ACK_WAIT. Next cycle audio_en=0, alarm_active=0; done stays 0.
  - ack has priority over both timeout and phase change in the same cycle.
- ACK_WAIT:
  - Stay while ack=1; ack=0 -> IDLE.
  - endtime is ignored here, so a held button cannot retrigger the alarm.
- endtime while in BEEP/GAP is ignored; no restart and no counter change.
- reset asserted mid-alarm: immediate return to the reset values above, with no done pulse.
- audioselection only ever takes values 0..NUM_TONES-1; upper bits are 0.

Test Plan (TICK_DIV=4, BEEP_BEATS=2, GAP_BEATS=1, ALARM_BEATS=10, NUM_TONES=5):
- Reset then idle 50 cycles -> all outputs 0; endtime pulse at cycle T -> audio_en=1, alarm_active=1, audioselection=0 at T+1.
- Free run after endtime -> audio_en high 8 cycles, low 4, high 8...; audioselection 0,1,2,3 on successive beeps.
- No ack -> after 40 cycles (10 beats) audio_en=0, alarm_active=0, done=1 for exactly 1 cycle; final audioselection=3.
- ack=1 held 20 cycles mid-BEEP, with endtime pulsed during the hold -> audio_en=0 next cycle, done never 1, state returns to IDLE only after ack=0, no retrigger.
- ack=1 and endtime=1 in the same IDLE cycle -> stays IDLE, audio_en remains 0.
- reset=0 asserted asynchronously mid-GAP -> outputs 0 before the next clock edge; a new endtime after release restarts with audioselection=0.
